// File: rtl/rv_stream_rr_arbiter_pkg.sv
// Shared helpers for the round-robin stream arbiter and its priority encoder.
package rv_stream_rr_arbiter_pkg;

    // Index width that stays at least one bit wide, even for a single requester.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rv_stream_rr_arbiter_priority_encoder.sv
// Rotating find-first: picks the first set request after last_grant, wrapping at N-1.
module rv_stream_rr_arbiter_priority_encoder
    import rv_stream_rr_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    requests,
    input  logic [SELW-1:0] last_grant,
    output logic [N-1:0]    grant_onehot,
    output logic [SELW-1:0] grant_index,
    output logic            grant_valid
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    int             start;
    int             offset;

    // Rotate so the slot after last_grant sits at bit 0, find-first, then un-rotate.
    always_comb begin
        start        = (int'(last_grant) + 1) % N;
        doubled      = {requests, requests};
        rotated      = doubled[start +: N];
        grant_valid  = 1'b0;
        offset       = 0;
        for (int k = 0; k < N; k++) begin
            if (!grant_valid && rotated[k]) begin
                grant_valid = 1'b1;
                offset      = k;
            end
        end
        grant_index  = SELW'((start + offset) % N);
        grant_onehot = '0;
        if (grant_valid) begin
            grant_onehot[grant_index] = 1'b1;
        end
    end

endmodule

// File: rtl/rv_stream_rr_arbiter.sv
// N-to-1 round-robin valid/ready arbiter with optional grant lock and optional output register.
module rv_stream_rr_arbiter
    import rv_stream_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter bit LOCK_EN  = 1'b1,
    parameter bit BUFFERED = 1'b1,
    localparam int SELW    = clog2_min1(NUM_REQS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
);

    logic [SELW-1:0]     cand;
    logic [NUM_REQS-1:0] cand_onehot;
    logic                cand_valid;
    logic [DATAW-1:0]    cand_data;
    logic                stage_ready;
    logic                accept;

    assign cand_data = data_in[int'(cand)*DATAW +: DATAW];
    assign accept    = cand_valid & stage_ready;
    assign ready_in  = accept ? cand_onehot : '0;

    generate
        if (NUM_REQS == 1) begin : g_single
            assign cand        = '0;
            assign cand_onehot = 1'b1;
            assign cand_valid  = valid_in[0];
        end else begin : g_arb
            logic [SELW-1:0]     last_grant;
            logic [SELW-1:0]     lock_idx;
            logic                lock;
            logic                locked;
            logic [SELW-1:0]     enc_index;
            logic [NUM_REQS-1:0] enc_onehot;
            logic                enc_valid;

            rv_stream_rr_arbiter_priority_encoder #(
                .N (NUM_REQS)
            ) u_prio (
                .requests     (valid_in),
                .last_grant   (last_grant),
                .grant_onehot (enc_onehot),
                .grant_index  (enc_index),
                .grant_valid  (enc_valid)
            );

            assign locked = LOCK_EN && lock;

            // A held lock overrides arbitration so a stalled beat cannot be overtaken.
            always_comb begin
                cand        = enc_index;
                cand_onehot = enc_onehot;
                cand_valid  = enc_valid;
                if (locked) begin
                    cand                  = lock_idx;
                    cand_onehot           = '0;
                    cand_onehot[lock_idx] = 1'b1;
                    cand_valid            = valid_in[lock_idx];
                end
            end

            // A locked requester that drops valid releases the lock with the pointer untouched.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    last_grant <= SELW'(NUM_REQS - 1);
                    lock       <= 1'b0;
                    lock_idx   <= '0;
                end else if (accept) begin
                    last_grant <= cand;
                    lock       <= 1'b0;
                end else begin
                    lock <= LOCK_EN && cand_valid;
                    if (cand_valid) begin
                        lock_idx <= cand;
                    end
                end
            end
        end
    endgenerate

    generate
        if (BUFFERED) begin : g_reg
            logic             vld_p1;
            logic [DATAW-1:0] data_p1;
            logic [SELW-1:0]  sel_p1;

            // Output stage (p1): one-entry skid, pop and push in the same cycle allowed.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                    sel_p1  <= '0;
                end else if (accept) begin
                    vld_p1  <= 1'b1;
                    data_p1 <= cand_data;
                    sel_p1  <= cand;
                end else if (ready_out) begin
                    vld_p1  <= 1'b0;
                end
            end

            assign stage_ready = ~vld_p1 | ready_out;
            assign valid_out   = vld_p1;
            assign data_out    = data_p1;
            assign sel_out     = sel_p1;
        end else begin : g_comb
            assign stage_ready = ready_out;
            assign valid_out   = cand_valid;
            assign data_out    = cand_data;
            assign sel_out     = cand;
        end
    endgenerate

endmodule

// File: tb/tb_rv_stream_rr_arbiter.sv
// Bench for rv_stream_rr_arbiter: buffered+locking and combinational+non-locking instances.
module tb_rv_stream_rr_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] valid_in = '0;
    logic [N-1:0] valid_b = '0;
    logic [N*W-1:0] data_in = '0;
    logic         ready_out = 1'b0;
    logic         ready_b = 1'b0;
    logic [N-1:0] ready_in;
    logic [N-1:0] rdy_b;
    logic         vo_a, vo_b;
    logic [W-1:0] do_a, do_b;
    logic [1:0]   so_a, so_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rv_stream_rr_arbiter #(
        .NUM_REQS (N), .DATAW (W), .LOCK_EN (1'b1), .BUFFERED (1'b1)
    ) dut_a (
        .clk (clk), .reset (reset), .valid_in (valid_in), .data_in (data_in),
        .ready_in (ready_in), .valid_out (vo_a), .data_out (do_a), .sel_out (so_a),
        .ready_out (ready_out)
    );

    rv_stream_rr_arbiter #(
        .NUM_REQS (N), .DATAW (W), .LOCK_EN (1'b0), .BUFFERED (1'b0)
    ) dut_b (
        .clk (clk), .reset (reset), .valid_in (valid_b), .data_in (data_in),
        .ready_in (rdy_b), .valid_out (vo_b), .data_out (do_b), .sel_out (so_b),
        .ready_out (ready_b)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: per-instance pointer, locked index (-1 = none) and output beat.
    int           m_lg [2];
    int           m_lk [2];
    bit           m_ov [2];
    logic [W-1:0] m_od [2];
    int           m_os [2];

    function automatic int scan(input int lg, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(lg + k) % N]) return (lg + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] lane(input int i);
        return data_in[i*W +: W];
    endfunction

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] v, rdy, exp_rdy;
        logic [W-1:0] dat;
        logic [1:0]   sel;
        bit r, vo, lock_en, buffered, cv, sr, acc;
        int cand;
        for (int n = 0; n < 2; n++) begin
            v        = (n == 0) ? valid_in : valid_b;
            r        = (n == 0) ? ready_out : ready_b;
            rdy      = (n == 0) ? ready_in : rdy_b;
            vo       = (n == 0) ? vo_a : vo_b;
            dat      = (n == 0) ? do_a : do_b;
            sel      = (n == 0) ? so_a : so_b;
            lock_en  = (n == 0);
            buffered = (n == 0);
            if (reset) begin
                m_lg[n] = N - 1;
                m_lk[n] = -1;
                m_ov[n] = 1'b0;
                m_od[n] = '0;
                m_os[n] = 0;
                if (buffered) begin
                    chk("rst_valid_out", vo, 0);
                    chk("rst_data_out", dat, 0);
                    chk("rst_sel_out", sel, 0);
                end
            end else begin
                cand    = (m_lk[n] >= 0) ? m_lk[n] : scan(m_lg[n], v);
                cv      = (cand >= 0) && v[cand];
                sr      = buffered ? (!m_ov[n] || r) : r;
                acc     = cv && sr;
                exp_rdy = acc ? (N'(1) << cand) : '0;
                chk(n == 0 ? "model_ready_in_a" : "model_ready_in_b", rdy, exp_rdy);
                if (buffered) begin
                    chk("model_valid_out_a", vo, m_ov[n]);
                    chk("model_data_out_a", dat, m_od[n]);
                    chk("model_sel_out_a", sel, m_os[n]);
                end else begin
                    chk("model_valid_out_b", vo, cv);
                    if (cv) begin
                        chk("model_data_out_b", dat, lane(cand));
                        chk("model_sel_out_b", sel, cand);
                    end
                end
                if (acc) begin
                    m_lg[n] = cand;
                    m_lk[n] = -1;
                    if (buffered) begin
                        m_ov[n] = 1'b1;
                        m_od[n] = lane(cand);
                        m_os[n] = cand;
                    end
                end else begin
                    if (buffered && m_ov[n] && r) m_ov[n] = 1'b0;
                    m_lk[n] = (lock_en && cv) ? cand : -1;
                end
            end
        end
    end

    task automatic cyc(input logic [N-1:0] v, input bit r);
        @(posedge clk); #1;
        reset = 1'b0; valid_in = v; ready_out = r;
        #1;
    endtask

    task automatic cycb(input logic [N-1:0] v, input bit r);
        @(posedge clk); #1;
        reset = 1'b0; valid_b = v; ready_b = r;
        #1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_in[i*W +: W] = 32'hA000_0000 + 32'(i);
        repeat (3) @(posedge clk);

        // Non-locking combinational instance: a stalled req2 is overtaken by req0.
        cycb(4'b0100, 1'b0);
        chk("b_stall_valid", vo_b, 1);
        chk("b_stall_sel", so_b, 2);
        chk("b_stall_rdy", rdy_b, 4'b0000);
        cycb(4'b0101, 1'b0);
        chk("b_overtake_sel", so_b, 0);
        chk("b_overtake_rdy", rdy_b, 4'b0000);
        cycb(4'b0101, 1'b1);
        chk("b_grant0_rdy", rdy_b, 4'b0001);
        chk("b_grant0_data", do_b, 32'hA000_0000);
        cycb(4'b0101, 1'b1);
        chk("b_grant2_rdy", rdy_b, 4'b0100);
        chk("b_grant2_sel", so_b, 2);
        cycb(4'b0000, 1'b0);

        // Fairness from reset: first grant to req0, then 0,1,2,3,0,1 one cycle later.
        cyc(4'b1111, 1'b1);
        chk("a_first_rdy", ready_in, 4'b0001);
        chk("a_first_vo", vo_a, 0);
        for (int k = 0; k < 6; k++) begin
            cyc(4'b1111, 1'b1);
            chk("a_fair_sel", so_a, k % 4);
            chk("a_fair_vo", vo_a, 1);
            chk("a_fair_rdy", ready_in, N'(1) << ((k + 1) % 4));
        end

        // Asynchronous reset mid-stream.
        reset = 1'b1; #1;
        chk("a_rst_async_vo", vo_a, 0);
        chk("a_rst_async_sel", so_a, 0);
        cyc(4'b1111, 1'b1);
        chk("a_after_rst_rdy", ready_in, 4'b0001);

        // Lock: req2 stalls behind a full register, req0 must not overtake.
        cyc(4'b1000, 1'b1);
        chk("a_lk_setup_rdy", ready_in, 4'b1000);
        chk("a_lk_setup_sel", so_a, 0);
        cyc(4'b0100, 1'b0);
        chk("a_lk_stall_rdy", ready_in, 4'b0000);
        chk("a_lk_stall_sel", so_a, 3);
        cyc(4'b0101, 1'b0);
        chk("a_lk_hold_rdy", ready_in, 4'b0000);
        cyc(4'b0101, 1'b1);
        chk("a_lk_rel_rdy", ready_in, 4'b0100);
        chk("a_lk_rel_sel", so_a, 3);
        cyc(4'b0101, 1'b1);
        chk("a_lk_next_rdy", ready_in, 4'b0001);
        chk("a_lk_next_sel", so_a, 2);
        cyc(4'b0000, 1'b1);
        chk("a_lk_last_sel", so_a, 0);
        chk("a_lk_idle_rdy", ready_in, 4'b0000);

        // Wrap-around with sparse requests.
        cyc(4'b1000, 1'b1);
        chk("a_wrap_setup_rdy", ready_in, 4'b1000);
        cyc(4'b1010, 1'b1);
        chk("a_wrap_rdy1", ready_in, 4'b0010);
        cyc(4'b1010, 1'b1);
        chk("a_wrap_rdy3", ready_in, 4'b1000);
        chk("a_wrap_sel1", so_a, 1);
        cyc(4'b1010, 1'b1);
        chk("a_wrap_rdy1b", ready_in, 4'b0010);
        chk("a_wrap_sel3", so_a, 3);

        // Backpressure hold of a registered beat.
        data_in[1*W +: W] = 32'hDEAD_BEEF;
        cyc(4'b0010, 1'b1);
        chk("a_bp_push_rdy", ready_in, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0010, 1'b0);
            chk("a_bp_hold_data", do_a, 32'hDEAD_BEEF);
            chk("a_bp_hold_sel", so_a, 1);
            chk("a_bp_hold_vo", vo_a, 1);
            chk("a_bp_hold_rdy", ready_in, 4'b0000);
        end
        cyc(4'b0010, 1'b1);
        chk("a_bp_accept_rdy", ready_in, 4'b0010);
        chk("a_bp_accept_data", do_a, 32'hDEAD_BEEF);
        cyc(4'b0000, 1'b1);
        chk("a_bp_second_vo", vo_a, 1);
        cyc(4'b0000, 1'b1);
        chk("a_bp_drain_vo", vo_a, 0);

        // Randomized traffic with held/dropped valids, backpressure and sporadic resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) != 0) valid_in = N'($urandom) | N'($urandom);
            if ($urandom_range(0, 3) != 0) valid_b = N'($urandom) & N'($urandom);
            ready_out = ($urandom_range(0, 2) != 0);
            ready_b   = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N; i++) data_in[i*W +: W] = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; valid_in = '0; valid_b = '0;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
